// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator for sigma-delta bitstreams.
// Each channel has N integrators that update on every input strobe. One comb engine is shared by
// all channels. Once per frame of 2^LOG2R samples it runs the N comb stages on a snapshot of every
// channel, one stage per cycle and one channel after another. It emits one tagged word per channel.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   Xin         packed samples, channel c at [c*IN_W +: IN_W], signed
//   Xin_vld     one-cycle sample strobe common to all channels
//   Filter_out  signed decimated output, top OUT_W bits of the RW-bit result (optionally rounded)
//   Filter_ch   channel index of Filter_out
//   rdy         one-cycle pulse, Filter_out/Filter_ch valid
//   busy        comb engine active
//   overrun     sticky, a decimation tick arrived while the engine was busy and was dropped
module cic_decim_mc #(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned CH    = 2,
  parameter int unsigned N     = 5,
  parameter int unsigned LOG2R = 6,
  parameter int unsigned RW    = IN_W + N * LOG2R,
  parameter int unsigned OUT_W = RW,
  parameter int unsigned ROUND = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CH*IN_W-1:0]                     Xin,
  input  logic                                   Xin_vld,
  output logic signed [OUT_W-1:0]                Filter_out,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] Filter_ch,
  output logic                                   rdy,
  output logic                                   busy,
  output logic                                   overrun
);

  localparam int unsigned ChW = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned StW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StComb} state_e;

  logic [RW-1:0]    integ_q [CH][N];
  logic [RW-1:0]    integ_d [CH][N];
  logic [RW-1:0]    comb_q  [CH][N];
  logic [RW-1:0]    comb_d  [CH][N];
  logic [RW-1:0]    snap_q  [CH];
  logic [RW-1:0]    snap_d  [CH];
  logic [RW-1:0]    v_q, v_d;
  logic [LOG2R-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  state_e           state_q, state_d;
  logic [ChW-1:0]   ch_q, ch_d;
  logic [StW-1:0]   stage_q, stage_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [ChW-1:0]   och_q, och_d;
  logic             rdy_q, rdy_d;
  logic             ovr_q, ovr_d;
  logic [RW-1:0]    diff;
  logic [OUT_W-1:0] scaled;

  // Integrators: every stage updates from the old value of its predecessor.
  always_comb begin
    integ_d = integ_q;
    if (Xin_vld) begin
      for (int c = 0; c < CH; c++) begin
        integ_d[c][0] = integ_q[c][0] +
                        {{(RW-IN_W){Xin[c*IN_W + IN_W - 1]}}, Xin[c*IN_W +: IN_W]};
        for (int k = 1; k < N; k++) begin
          integ_d[c][k] = integ_q[c][k] + integ_q[c][k-1];
        end
      end
    end
  end

  // Decimation counter wraps naturally at R-1 (all ones).
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (Xin_vld) begin
      cnt_d  = cnt_q + LOG2R'(1);
      tick_d = (cnt_q == '1);
    end
  end

  // Output of the last comb stage of the current channel.
  assign diff = v_q - comb_q[ch_q][N-1];

  if (ROUND == 0 || OUT_W == RW) begin : g_trunc
    assign scaled = diff[RW-1 -: OUT_W];
    if (OUT_W < RW) begin : g_drop
      logic unused_lsb;
      assign unused_lsb = ^diff[RW-OUT_W-1:0];
    end
  end else begin : g_round
    localparam logic [RW:0]      Half   = {{RW{1'b0}}, 1'b1} << (RW - OUT_W - 1);
    localparam logic [OUT_W-1:0] MaxPos = {OUT_W{1'b1}} >> 1;
    logic [RW:0] rsum;
    logic        unused_lsb;
    assign rsum = {diff[RW-1], diff} + Half;
    // Carry into bit RW-1 without a sign change means a positive overflow.
    assign scaled = (!rsum[RW] && rsum[RW-1]) ? MaxPos : rsum[RW-1 -: OUT_W];
    assign unused_lsb = ^rsum[RW-OUT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    v_d     = v_q;
    ch_d    = ch_q;
    stage_d = stage_q;
    comb_d  = comb_q;
    out_d   = out_q;
    och_d   = och_q;
    rdy_d   = 1'b0;
    ovr_d   = ovr_q;
    unique case (state_q)
      StIdle: begin
        if (tick_q) begin
          // Snapshots decouple the engine from integrators that keep running.
          for (int c = 0; c < CH; c++) begin
            snap_d[c] = integ_q[c][N-1];
          end
          v_d     = integ_q[0][N-1];
          ch_d    = '0;
          stage_d = '0;
          state_d = StComb;
        end
      end
      StComb: begin
        if (tick_q) begin
          ovr_d = 1'b1;
        end
        v_d                    = v_q - comb_q[ch_q][stage_q];
        comb_d[ch_q][stage_q]  = v_q;
        stage_d                = stage_q + StW'(1);
        if (stage_q == StW'(N - 1)) begin
          out_d = scaled;
          och_d = ch_q;
          rdy_d = 1'b1;
          if (ch_q != ChW'(CH - 1)) begin
            ch_d    = ch_q + ChW'(1);
            v_d     = snap_q[ch_q + ChW'(1)];
            stage_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < N; k++) begin
          integ_q[c][k] <= '0;
          comb_q[c][k]  <= '0;
        end
        snap_q[c] <= '0;
      end
      v_q     <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      state_q <= StIdle;
      ch_q    <= '0;
      stage_q <= '0;
      out_q   <= '0;
      och_q   <= '0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      integ_q <= integ_d;
      comb_q  <= comb_d;
      snap_q  <= snap_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      ch_q    <= ch_d;
      stage_q <= stage_d;
      out_q   <= out_d;
      och_q   <= och_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Filter_out = out_q;
  assign Filter_ch  = och_q;
  assign rdy        = rdy_q;
  assign busy       = (state_q == StComb);
  assign overrun    = ovr_q;

endmodule

// File: doc/cic_decim_mc.md
# cic_decim_mc

Parametrised multi-channel CIC decimator for Sigma-Delta bitstreams. It is the generalised successor of the fixed Mul_CIC front end. N order, 2^LOG2R decimation, input width, output width/rounding and channel count are all parameters. Per-channel integrators run on every input strobe. One shared comb engine processes the channels sequentially at the decimated rate and emits one tagged output word per channel per frame.

## Interface
- IN_W, 2: signed input sample width per channel (bitstream: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0).
- CH, 2: channel count, ≥1.
- N, 5: CIC order (integrator/comb stages), ≥1.
- LOG2R, 6: log2 of decimation ratio R, ≥1.
- RW, IN_W+N*LOG2R: internal register width. Derived; do not override.
- OUT_W, RW: output width, ≤RW. Output is the top OUT_W bits of the RW result.
- ROUND, 0: 0 = truncate, 1 = round half up with positive saturation.
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- Xin  in  CH*IN_W  packed channel samples; channel c occupies bits [c*IN_W +: IN_W].
- Xin_vld  in  1  one-cycle input sample strobe, common to all channels.
- Filter_out  out  OUT_W  signed decimated output.
- Filter_ch  out  max(1,$clog2(CH))  channel index of Filter_out.
- rdy  out  1  one-cycle pulse: Filter_out/Filter_ch valid.
- busy  out  1  comb engine active.
- overrun  out  1  sticky: decimation tick dropped because engine was busy.

## Operation
- Arithmetic: all integrator/comb math is RW-bit two's complement, modular wrap. Inputs are sign-extended to RW.
- Integrators, on Xin_vld, per channel, all stages simultaneously from old values: I1 <= I1 + x; Ik <= Ik + I(k-1).
- Decimation counter: 0..R-1, advances on Xin_vld. The Xin_vld at count R-1 sets tick_r for the next cycle and wraps the counter to 0.
- FSM states: IDLE and COMB.
- IDLE + tick_r: snapshot S[c] <= I_N[c] for all c; v <= I_N[0]; ch <= 0; stage <= 0; go to COMB.
- COMB, one stage per cycle: v <= v − D[ch][stage]; D[ch][stage] <= v.
- At stage N−1: Filter_out <= scale(v − D[ch][N−1]); Filter_ch <= ch; rdy <= 1.
  - If ch < CH−1: ch++, v <= S[ch+1], stage <= 0.
  - Otherwise: go to IDLE.
- scale: ROUND=0 → bits [RW−1 -: OUT_W].
- scale, ROUND=1 → add 2^(RW−OUT_W−1) in RW+1 bits, then take the top OUT_W bits. A positive result beyond the OUT_W max saturates to 2^(OUT_W−1)−1. OUT_W=RW bypasses rounding.
- tick_r while busy: tick dropped, snapshot not taken, overrun <= 1. Integrators and counter are unaffected.
- Xin_vld during COMB is always accepted by the integrators. Snapshots isolate the engine from those updates.
- busy = (state == COMB).

## Timing
- Reset: all integrators, combs, snapshots and counters clear to 0. State = IDLE. Filter_out=0, Filter_ch=0, rdy=0, busy=0, overrun=0.
- Reset mid-COMB aborts the frame; no rdy for that frame.
- R-th Xin_vld in cycle t: tick_r in cycle t+1; busy high cycles t+2..t+1+CH*N.
- Channel c output: rdy high in cycle t+2+(c+1)*N. With N=1, rdy pulses are back-to-back.
- Overrun-free requirement: Xin_vld spacing × R > CH*N+2 cycles. At 512 kHz and 50 MHz (~98 cycles/sample), this always holds.
- Steady-state DC gain is R^N: constant input x yields x·2^(N·LOG2R) before scaling. The first N outputs per channel are transient.

## Test plan
- DC: CH=2, N=5, LOG2R=6, OUT_W=32, ROUND=0. Ch0=+1, ch1=−1, Xin_vld every 98 cycles. From output 6 onward, expect ch0 = 1073741824 and ch1 = −1073741824, alternating with Filter_ch 0,1.
- Impulse: N=1, LOG2R=2, CH=1. One +1 sample at frame start, zeros after. Expect outputs 1, then 0 forever.
- Latency: N=5, CH=2. R-th Xin_vld in cycle t. Expect rdy at t+7 (Filter_ch=0) and t+12 (Filter_ch=1); busy exactly t+2..t+11.
- Rounding: N=1, LOG2R=2, IN_W=2 (RW=4), OUT_W=3, CH=1. Frame +1,+1,+1,0 → ROUND=1 gives 2, ROUND=0 gives 1. Frame +1×4 → 2 in both modes.
- Overrun: N=5, CH=2, LOG2R=1, Xin_vld every cycle. Expect overrun=1 after the second tick. Every rdy burst is a complete CH-channel set. overrun stays 1 until rst.
- Reset mid-frame: rst during cycle t+4 of a frame. No rdy follows; next cycle all outputs are 0 and overrun=0. After resuming stimulus, the DC test values are reproduced.
